hba_fifo_slave: RTL
===================

# hba_fifo_slave

HBA slave peripheral that buffers bytes from a peripheral-side strobe source, such as a UART receiver, in a small FIFO and exposes them to the HBA master through four registers. It sits directly upstream of the slave OR stage. It drives one bit of that stage's `hba_xferack_slave` vector and one `hba_dbus_slaveN` input, holding both at zero whenever it is not acknowledging, as the OR bus requires. It also raises a level interrupt when the FIFO fill reaches a programmable threshold.

## Interface
- `DBUS_WIDTH`, 8: data width; must be 8.
- `ADDR_WIDTH`, 12: HBA address width.
- `REG_ADDR_WIDTH`, 8: low address bits that select a register; the upper `ADDR_WIDTH-REG_ADDR_WIDTH` bits select the peripheral.
- `PERIPH_ADDR`, 0: peripheral number this slave answers to.
- `FIFO_DEPTH_LOG2`, 4: FIFO depth is `2**FIFO_DEPTH_LOG2`; range 1..4.

- `hba_clk`, in, 1: sole clock; all logic is rising-edge.
- `hba_reset_n`, in, 1: asynchronous, active-low reset.
- `hba_select`, in, 1: master transaction request.
- `hba_rnw`, in, 1: 1 = read, 0 = write.
- `hba_abus`, in, `ADDR_WIDTH`: address.
- `hba_dbus`, in, `DBUS_WIDTH`: master write data.
- `hba_xferack_slave`, out, 1: one-cycle transfer acknowledge.
- `hba_dbus_slave`, out, `DBUS_WIDTH`: read data; 0 except during an acknowledged read.
- `hba_interrupt_slave`, out, 1: level interrupt.
- `in_data`, in, 8: byte from the peripheral side.
- `in_strobe`, in, 1: one-cycle push request; there is no backpressure.

## Operation
- The block is addressed when `hba_select` is high and `hba_abus[ADDR_WIDTH-1:REG_ADDR_WIDTH]` equals `PERIPH_ADDR`. The register index is `hba_abus[REG_ADDR_WIDTH-1:0]`.
- Register map:
  - 0 DATA (read-only): a read returns the FIFO head and pops it. Reading while empty returns 0 and leaves the pointers unchanged.
  - 1 STATUS (read-only):
    - bit 7: overflow (sticky).
    - bit 6: full.
    - bit 5: empty.
    - bits 4:0: count, 0..`2**FIFO_DEPTH_LOG2`.
  - 2 CONTROL (read/write):
    - bit 0: interrupt enable.
    - bit 1: clear. Writing 1 flushes the pointers and count and clears overflow. This bit is self-clearing and always reads back as 0.
    - Other bits read 0.
  - 3 THRESH (read/write): 5-bit threshold; upper bits read 0.
  - Other indices: acknowledged; reads return 0 and writes are ignored.
- Push: when `in_strobe` is high and the FIFO is not full, store `in_data` at the write pointer, advance the write pointer, and increment count.
  - If full: drop the byte and set overflow, evaluating fullness before any same-cycle pop.
- Pop and push in the same cycle (FIFO not full): both take effect and count is unchanged.
- Clear and push in the same cycle: clear wins, the byte is dropped, and overflow stays 0.
- Pointers are `FIFO_DEPTH_LOG2` bits wide and wrap modulo the depth. Count is a separate `FIFO_DEPTH_LOG2+1`-bit counter.
- `hba_interrupt_slave` = enable AND (count != 0) AND (count >= THRESH). It is combinational from registered state, so it has no glitch path from the bus.

## Timing
- Reset values: `hba_xferack_slave`=0, `hba_dbus_slave`=0, `hba_interrupt_slave`=0, pointers=0, count=0, overflow=0, enable=0, THRESH=0. Memory contents are don't-care.
- Handshake state machine:
  - IDLE: if addressed, go to ACK at the next edge. At that edge:
    - latch the read data into `hba_dbus_slave` (writes drive 0);
    - perform any register write or DATA pop.
  - ACK: `hba_xferack_slave`=1 for exactly this cycle; go to WAIT.
  - WAIT: hold `hba_xferack_slave`=0 and `hba_dbus_slave`=0 until `hba_select` is low, then go to IDLE. This prevents a double-ack while the master releases select.
- Latency: ack is asserted one cycle after `hba_select` is first seen addressed.
- A push in the same cycle as a STATUS read is not visible in that read; it appears in the next read.
- Reset asserted mid-transaction: all state returns to reset values immediately (asynchronously), ack is abandoned, and the block is in IDLE after release.

## Test plan
- Reset, then read STATUS → ack exactly 1 cycle after select; data = 0x20 (empty, count 0); interrupt = 0.
- Push 0x11, 0x22, 0x33, then read DATA three times → returns 0x11, 0x22, 0x33. A fourth read returns 0x00 and STATUS = 0x20.
- Push 17 bytes at depth 16 → STATUS = 0xD0 (overflow, full, count 16). The 17th byte is absent; the 16th read returns the 16th byte.
- Write THRESH=3 and CONTROL=0x01, push 2 bytes → interrupt = 0; third push → interrupt = 1; one DATA read → interrupt = 0.
- Hold `hba_select` high for 5 cycles on a DATA read with 2 bytes queued → exactly one ack and exactly one pop; count = 1.
- Write CONTROL=0x03 in the same cycle as an `in_strobe` while overflow is set → STATUS = 0x20, CONTROL reads 0x01.

Source files
------------

// File: rtl/hba_fifo_slave_if.sv
// HBA bus bundle between the master/OR stage and one slave peripheral.
// Handshake: the master raises hba_select with address, rnw and write data and
// holds them stable until it has seen hba_xferack_slave for one cycle; the
// slave acknowledges exactly once per select assertion and keeps
// hba_dbus_slave at zero in every cycle that is not an acknowledged read.
interface hba_fifo_slave_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DBUS_WIDTH = 8
) ();
  logic                  hba_select;
  logic                  hba_rnw;
  logic [ADDR_WIDTH-1:0] hba_abus;
  logic [DBUS_WIDTH-1:0] hba_dbus;
  logic                  hba_xferack_slave;
  logic [DBUS_WIDTH-1:0] hba_dbus_slave;
  logic                  hba_interrupt_slave;

  modport master (
    output hba_select,
    output hba_rnw,
    output hba_abus,
    output hba_dbus,
    input  hba_xferack_slave,
    input  hba_dbus_slave,
    input  hba_interrupt_slave
  );

  modport slave (
    input  hba_select,
    input  hba_rnw,
    input  hba_abus,
    input  hba_dbus,
    output hba_xferack_slave,
    output hba_dbus_slave,
    output hba_interrupt_slave
  );
endinterface

// File: rtl/hba_fifo_slave.sv
// HBA slave that buffers peripheral-side bytes in a small FIFO and exposes
// DATA / STATUS / CONTROL / THRESH registers to the HBA master, with a level
// interrupt when the fill level reaches a programmable threshold.
module hba_fifo_slave #(
  parameter int DBUS_WIDTH      = 8,
  parameter int ADDR_WIDTH      = 12,
  parameter int REG_ADDR_WIDTH  = 8,
  parameter int PERIPH_ADDR     = 0,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic                  hba_clk,
  input  logic                  hba_reset_n,
  hba_fifo_slave_if.slave       hba,
  input  logic [DBUS_WIDTH-1:0] in_data,
  input  logic                  in_strobe,
  output logic [1:0]            state_dbg
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int CW    = FIFO_DEPTH_LOG2 + 1;
  localparam int PW    = ADDR_WIDTH - REG_ADDR_WIDTH;

  localparam logic [PW-1:0]             PERIPH_SEL = PW'(PERIPH_ADDR);
  localparam logic [REG_ADDR_WIDTH-1:0] IDX_DATA   = REG_ADDR_WIDTH'(0);
  localparam logic [REG_ADDR_WIDTH-1:0] IDX_STATUS = REG_ADDR_WIDTH'(1);
  localparam logic [REG_ADDR_WIDTH-1:0] IDX_CTRL   = REG_ADDR_WIDTH'(2);
  localparam logic [REG_ADDR_WIDTH-1:0] IDX_THRESH = REG_ADDR_WIDTH'(3);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [DBUS_WIDTH-1:0]      mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]              count_q;
  logic                       ovf_q;
  logic                       en_q;
  logic [4:0]                 thresh_q;
  logic [DBUS_WIDTH-1:0]      rdata_q;

  logic                      addressed;
  logic                      take;
  logic                      xferack;
  logic                      full;
  logic                      empty;
  logic                      do_push;
  logic                      do_pop;
  logic                      do_clear;
  logic                      wr_ctrl;
  logic                      wr_thresh;
  logic [REG_ADDR_WIDTH-1:0] reg_idx;
  logic [4:0]                count_5;
  logic [DBUS_WIDTH-1:0]     rd_mux;
  logic                      unused_wdata_bits;

  assign reg_idx   = hba.hba_abus[REG_ADDR_WIDTH-1:0];
  assign addressed = hba.hba_select &&
                     (hba.hba_abus[ADDR_WIDTH-1:REG_ADDR_WIDTH] == PERIPH_SEL);
  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign count_5   = 5'(count_q);

  // Only the low five write-data bits ever land in a register.
  assign unused_wdata_bits = ^hba.hba_dbus[DBUS_WIDTH-1:5];

  // Bus side effects happen on the edge that moves IDLE -> ACK.
  assign do_pop    = take && hba.hba_rnw && (reg_idx == IDX_DATA) && !empty;
  assign wr_ctrl   = take && !hba.hba_rnw && (reg_idx == IDX_CTRL);
  assign wr_thresh = take && !hba.hba_rnw && (reg_idx == IDX_THRESH);
  assign do_clear  = wr_ctrl && hba.hba_dbus[1];
  // Fullness is judged before any same-cycle pop; a clear swallows the byte.
  assign do_push   = in_strobe && !full && !do_clear;

  // Handshake state register.
  always_ff @(posedge hba_clk or negedge hba_reset_n) begin
    if (!hba_reset_n) state_q <= ST_IDLE;
    else              state_q <= state_d;
  end

  // Next state, one-cycle ack, and the "take this transaction" strobe.
  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    xferack = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (addressed) begin
          take    = 1'b1;
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        xferack = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // Stay here until the master drops select so one request gets one ack.
        if (!hba.hba_select) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Read data mux from state as it stands before the acknowledging edge.
  always_comb begin
    rd_mux = '0;
    case (reg_idx)
      IDX_DATA:   rd_mux = empty ? '0 : mem[rd_ptr_q];
      IDX_STATUS: rd_mux = {ovf_q, full, empty, count_5};
      IDX_CTRL:   rd_mux = {7'b0, en_q};
      IDX_THRESH: rd_mux = {3'b0, thresh_q};
      default:    rd_mux = '0;
    endcase
  end

  // Read data is latched at the take edge and is zero in every other cycle.
  always_ff @(posedge hba_clk or negedge hba_reset_n) begin
    if (!hba_reset_n)          rdata_q <= '0;
    else if (take && hba.hba_rnw) rdata_q <= rd_mux;
    else                       rdata_q <= '0;
  end

  // FIFO pointers, fill count and sticky overflow.
  always_ff @(posedge hba_clk or negedge hba_reset_n) begin
    if (!hba_reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else if (do_clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + FIFO_DEPTH_LOG2'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + FIFO_DEPTH_LOG2'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (in_strobe && full) ovf_q <= 1'b1;
    end
  end

  // Interrupt enable and threshold registers.
  always_ff @(posedge hba_clk or negedge hba_reset_n) begin
    if (!hba_reset_n) begin
      en_q     <= 1'b0;
      thresh_q <= '0;
    end else begin
      if (wr_ctrl)   en_q     <= hba.hba_dbus[0];
      if (wr_thresh) thresh_q <= hba.hba_dbus[4:0];
    end
  end

  // Storage array; contents need no reset.
  always_ff @(posedge hba_clk) begin
    if (do_push) mem[wr_ptr_q] <= in_data;
  end

  assign hba.hba_xferack_slave   = xferack;
  assign hba.hba_dbus_slave      = rdata_q;
  assign hba.hba_interrupt_slave = en_q && !empty && (count_5 >= thresh_q);
  assign state_dbg               = state_q;

endmodule
